mux_pipe_n: RTL and testbench

MUX_PIPE_N -- requirements
Module: mux_pipe_n

---
 rtl/mux_pkg.sv | 26 ++
 rtl/mux_n_comb.sv | 27 ++
 rtl/mux_pipe_n.sv | 104 ++++++++++
 tb/tb_mux_pipe_n.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared types, default parameters and width helper for the mux pipeline slice.
package mux_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam int unsigned DEF_WIDTH  = 3;
  localparam int unsigned DEF_NUM_IN = 2;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << r) < 64'(v)) r = r + 1;
    end
    return r;
  endfunction

  function automatic int unsigned sel_width(input int unsigned n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/mux_n_comb.sv
// Combinational channel select: picks channel sel from the flat in_data bus.
// An out-of-range sel yields zero data with out_err set.
module mux_n_comb
  import mux_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned NUM_IN = DEF_NUM_IN,
  localparam int unsigned SEL_W = sel_width(NUM_IN)
) (
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        sel,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_err
);

  always_comb begin
    out_data = '0;
    out_err  = 1'b1;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      if (sel == SEL_W'(k)) begin
        out_data = in_data[k*WIDTH +: WIDTH];
        out_err  = 1'b0;
      end
    end
  end

endmodule

// File: rtl/mux_pipe_n.sv
// Registered N-way mux behind a 2-entry skid buffer (head, skid).
// Ports: clk, rst_n (sync, active-low); in_data/in_sel/in_valid/in_ready push side;
// out_data/out_err/out_valid/out_ready pop side. in_ready depends on state only.
module mux_pipe_n
  import mux_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned NUM_IN = DEF_NUM_IN,
  localparam int unsigned SEL_W = sel_width(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_err,
  output logic                    out_valid,
  input  logic                    out_ready
);

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  head_data, skid_data;
  logic              head_err, skid_err;
  logic [WIDTH-1:0]  sel_data;
  logic              sel_err;
  logic              push, pop;
  logic              load_head_new, load_head_skid, load_skid;

  mux_n_comb #(
    .WIDTH  (WIDTH),
    .NUM_IN (NUM_IN)
  ) u_sel (
    .in_data  (in_data),
    .sel      (in_sel),
    .out_data (sel_data),
    .out_err  (sel_err)
  );

  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign out_data  = head_data;
  assign out_err   = head_err;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  always_comb begin
    state_d        = state_q;
    load_head_new  = 1'b0;
    load_head_skid = 1'b0;
    load_skid      = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (push) begin
          state_d       = ONE;
          load_head_new = 1'b1;
        end
      end
      ONE: begin
        if (push && pop) begin
          load_head_new = 1'b1;
        end else if (push) begin
          state_d   = FULL;
          load_skid = 1'b1;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          state_d        = ONE;
          load_head_skid = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= EMPTY;
      head_data <= '0;
      head_err  <= 1'b0;
      skid_data <= '0;
      skid_err  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load_head_new) begin
        head_data <= sel_data;
        head_err  <= sel_err;
      end else if (load_head_skid) begin
        head_data <= skid_data;
        head_err  <= skid_err;
      end
      if (load_skid) begin
        skid_data <= sel_data;
        skid_err  <= sel_err;
      end
    end
  end

endmodule

// File: tb/tb_mux_pipe_n.sv
module tb_mux_pipe_n;

  logic clk = 1'b0;
  logic rst_n;

  // default build: WIDTH=3, NUM_IN=2, SEL_W=1
  logic [5:0] in_data;
  logic       in_sel;
  logic       in_valid, in_ready;
  logic [2:0] out_data;
  logic       out_err, out_valid, out_ready;

  // NUM_IN=3 build: SEL_W=2
  logic [8:0] in_data3;
  logic [1:0] in_sel3;
  logic       in_valid3, in_ready3;
  logic [2:0] out_data3;
  logic       out_err3, out_valid3, out_ready3;

  int n_cmp = 0;
  int n_err = 0;

  logic [2:0] exp_d;
  logic       exp_e;
  logic [2:0] ch [3];

  always #5 clk = ~clk;

  mux_pipe_n dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_err   (out_err),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  mux_pipe_n #(.WIDTH(3), .NUM_IN(3)) dut3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data3),
    .in_sel    (in_sel3),
    .in_valid  (in_valid3),
    .in_ready  (in_ready3),
    .out_data  (out_data3),
    .out_err   (out_err3),
    .out_valid (out_valid3),
    .out_ready (out_ready3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n      = 1'b0;
    in_data    = 6'b111111;
    in_sel     = 1'b1;
    in_valid   = 1'b1;
    out_ready  = 1'b0;
    in_data3   = 9'h1ff;
    in_sel3    = 2'd0;
    in_valid3  = 1'b1;
    out_ready3 = 1'b0;

    // reset held two cycles with in_valid asserted
    tick();
    tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  32'(out_data),  32'd0);
    chk("rst_out_err",   32'(out_err),   32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst3_out_valid", 32'(out_valid3), 32'd0);
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    in_valid3 = 1'b0;
    tick();
    chk("post_rst_out_valid", 32'(out_valid), 32'd0);
    chk("post_rst_in_ready",  32'(in_ready),  32'd1);

    // basic select: channel 1 of {101,010}
    in_data   = {3'b101, 3'b010};
    in_sel    = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    chk("sel_out_valid", 32'(out_valid), 32'd1);
    chk("sel_out_data",  32'(out_data),  32'b101);
    chk("sel_out_err",   32'(out_err),   32'd0);
    in_valid = 1'b0;
    tick();
    chk("sel_drain_valid", 32'(out_valid), 32'd0);

    // backpressure: two pushes fill the buffer
    out_ready = 1'b0;
    in_data   = {3'b000, 3'b001};
    in_sel    = 1'b0;
    in_valid  = 1'b1;
    tick();
    chk("bp_first_ready", 32'(in_ready), 32'd1);
    in_data = {3'b110, 3'b000};
    in_sel  = 1'b1;
    tick();
    chk("bp_full_ready", 32'(in_ready),  32'd0);
    chk("bp_full_data",  32'(out_data),  32'b001);
    // push attempt while full must be ignored, head must hold
    in_data = {3'b111, 3'b111};
    tick();
    chk("bp_hold_data",  32'(out_data),  32'b001);
    chk("bp_hold_valid", 32'(out_valid), 32'd1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("bp_pop2_data",  32'(out_data),  32'b110);
    chk("bp_pop2_ready", 32'(in_ready),  32'd1);
    chk("bp_pop2_valid", 32'(out_valid), 32'd1);
    tick();
    chk("bp_empty_valid", 32'(out_valid), 32'd0);

    // illegal select on NUM_IN=3
    in_data3   = {3'b111, 3'b110, 3'b101};
    in_sel3    = 2'd3;
    in_valid3  = 1'b1;
    out_ready3 = 1'b1;
    tick();
    chk("ill_out_valid", 32'(out_valid3), 32'd1);
    chk("ill_out_data",  32'(out_data3),  32'd0);
    chk("ill_out_err",   32'(out_err3),   32'd1);
    in_sel3 = 2'd2;
    tick();
    chk("top_ch_data", 32'(out_data3), 32'b111);
    chk("top_ch_err",  32'(out_err3),  32'd0);
    in_valid3 = 1'b0;
    tick();
    chk("ill_drain_valid", 32'(out_valid3), 32'd0);

    // streaming: 16 back-to-back pushes, one pop per cycle
    in_valid3  = 1'b1;
    out_ready3 = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_data3 = 9'($urandom);
      in_sel3  = 2'($urandom_range(0, 3));
      ch[0] = in_data3[2:0];
      ch[1] = in_data3[5:3];
      ch[2] = in_data3[8:6];
      case (in_sel3)
        2'd0: begin exp_d = ch[0]; exp_e = 1'b0; end
        2'd1: begin exp_d = ch[1]; exp_e = 1'b0; end
        2'd2: begin exp_d = ch[2]; exp_e = 1'b0; end
        default: begin exp_d = 3'd0; exp_e = 1'b1; end
      endcase
      tick();
      chk($sformatf("stream%0d_valid", i), 32'(out_valid3), 32'd1);
      chk($sformatf("stream%0d_ready", i), 32'(in_ready3),  32'd1);
      chk($sformatf("stream%0d_data",  i), 32'(out_data3),  32'(exp_d));
      chk($sformatf("stream%0d_err",   i), 32'(out_err3),   32'(exp_e));
    end
    in_valid3 = 1'b0;
    tick();
    chk("stream_end_valid", 32'(out_valid3), 32'd0);

    // mid-operation reset from FULL
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_sel    = 1'b0;
    in_data   = {3'b000, 3'b011};
    tick();
    in_data = {3'b000, 3'b100};
    tick();
    chk("mid_full_ready", 32'(in_ready), 32'd0);
    rst_n     = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_data",  32'(out_data),  32'd0);
    chk("mid_rst_ready", 32'(in_ready),  32'd1);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    tick();
    chk("mid_lost_valid", 32'(out_valid), 32'd0);
    chk("mid_lost_data",  32'(out_data),  32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
